// File: rtl/lms_sequencer.sv
// rtl/lms_sequencer.sv - control sequencer for a time-multiplexed LMS adaptive FIR datapath
// One ready_in strobe runs: sample write, filter pass, error capture, optional coefficient update pass.
module lms_sequencer #(
  parameter int NTAPS    = 32,
  parameter int ADDR_W   = 5,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ready_in,
  input  logic              adapt_en_in,
  output logic              sample_we_out,
  output logic [ADDR_W-1:0] wr_ptr_out,
  output logic [ADDR_W-1:0] rd_addr_out,
  output logic [ADDR_W-1:0] coef_addr_out,
  output logic              mac_clear_out,
  output logic              mac_en_out,
  output logic              err_latch_out,
  output logic              coef_we_out,
  output logic [ADDR_W-1:0] coef_wr_addr_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              overrun_out
);

  typedef enum logic [2:0] {IDLE, LOAD, FILT, FFLUSH, ERR, UPD, UFLUSH, DONE} state_t;

  localparam logic [ADDR_W-1:0] TAP_LAST   = ADDR_W'(NTAPS - 1);
  localparam logic [ADDR_W-1:0] FLUSH_LAST = ADDR_W'(PIPE_LAT - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_hold, coef_hold;
  logic [ADDR_W-1:0] tap_rd;
  logic              pass;
  logic              overrun;
  logic [PIPE_LAT-1:0] dl_v;
  logic [ADDR_W-1:0]   dl_a [PIPE_LAT];

  // k doubles as the flush-cycle counter; it restarts at 0 on every state change.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ready_in) state_nxt = LOAD;
      LOAD:    state_nxt = FILT;
      FILT:    if (k == TAP_LAST) state_nxt = FFLUSH;
      FFLUSH:  if (k == FLUSH_LAST) state_nxt = ERR;
      ERR:     state_nxt = adapt_en_in ? UPD : DONE;
      UPD:     if (k == TAP_LAST) state_nxt = UFLUSH;
      UFLUSH:  if (k == FLUSH_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign pass   = (state == FILT) || (state == UPD);
  assign tap_rd = wr_ptr - k;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      k         <= '0;
      wr_ptr    <= '0;
      rd_hold   <= '0;
      coef_hold <= '0;
      overrun   <= 1'b0;
      dl_v      <= '0;
      for (int i = 0; i < PIPE_LAT; i++) dl_a[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == IDLE) k <= '0;
      else k <= k + 1'b1;
      if (pass) begin
        rd_hold   <= tap_rd;
        coef_hold <= k;
      end
      if (state == DONE) wr_ptr <= wr_ptr + 1'b1;
      if (ready_in && state != IDLE) overrun <= 1'b1;
      // Each update read reappears as a coefficient write PIPE_LAT cycles later.
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        dl_v[i] <= dl_v[i-1];
        dl_a[i] <= dl_a[i-1];
      end
      dl_v[0] <= (state == UPD);
      dl_a[0] <= k;
    end
  end

  assign sample_we_out    = (state == LOAD);
  assign mac_clear_out    = (state == LOAD);
  assign mac_en_out       = (state == FILT);
  assign err_latch_out    = (state == ERR);
  assign done_out         = (state == DONE);
  assign busy_out         = (state != IDLE);
  assign wr_ptr_out       = wr_ptr;
  assign rd_addr_out      = pass ? tap_rd : rd_hold;
  assign coef_addr_out    = pass ? k : coef_hold;
  assign coef_we_out      = dl_v[PIPE_LAT-1];
  assign coef_wr_addr_out = dl_v[PIPE_LAT-1] ? dl_a[PIPE_LAT-1] : '0;
  assign overrun_out      = overrun;

endmodule

// File: tb/tb_lms_sequencer.sv
// tb/tb_lms_sequencer.sv - scoreboard bench for lms_sequencer with randomized strobes
// A timeline model pushes expected datapath events; a negedge monitor pops and compares them.
module tb_lms_sequencer;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int L  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ready, adapt;
  logic sample_we, mac_clear, mac_en, err_latch, coef_we, busy, done, overrun;
  logic [AW-1:0] wr_ptr, rd_addr, coef_addr, coef_wr_addr;

  lms_sequencer #(.NTAPS(N), .ADDR_W(AW), .PIPE_LAT(L)) dut (
    .clk_in(clk), .rst_in(rst), .ready_in(ready), .adapt_en_in(adapt),
    .sample_we_out(sample_we), .wr_ptr_out(wr_ptr), .rd_addr_out(rd_addr),
    .coef_addr_out(coef_addr), .mac_clear_out(mac_clear), .mac_en_out(mac_en),
    .err_latch_out(err_latch), .coef_we_out(coef_we), .coef_wr_addr_out(coef_wr_addr),
    .busy_out(busy), .done_out(done), .overrun_out(overrun)
  );

  typedef struct {int cyc; int kind; int a; int b;} ev_t;
  localparam int K_LOAD = 0, K_MAC = 1, K_ERR = 2, K_CWR = 3, K_DONE = 4;

  ev_t exp_q[$];
  int  bs[$], be[$];
  int  ovc[$], ovv[$];
  int  cyc = 0;
  int  errors = 0, checks = 0;
  int  model_ptr = 0;
  bit  run_mon = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit busy_at(input int c);
    foreach (bs[i]) if (c >= bs[i] && c <= be[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int ov_at(input int c);
    int v = 0;
    foreach (ovc[i]) if (ovc[i] <= c) v = ovv[i];
    return v;
  endfunction

  function automatic void push_ev(input int c, input int kind, input int a, input int b);
    ev_t e;
    e.cyc = c; e.kind = kind; e.a = a; e.b = b;
    exp_q.push_back(e);
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe in the current cycle t; accepted only if the sequencer is idle.
  task automatic strobe(input bit ad);
    int t, p, done_c;
    t = cyc;
    ready = 1'b1;
    if (busy_at(t)) begin
      ovc.push_back(t + 1); ovv.push_back(1);
    end else begin
      adapt = ad;
      p = model_ptr;
      push_ev(t + 1, K_LOAD, p, 0);
      for (int k = 0; k < N; k++) push_ev(t + 2 + k, K_MAC, ((p - k) % N + N) % N, k);
      push_ev(t + 2 + N + L, K_ERR, 0, 0);
      if (ad) begin
        for (int k = 0; k < N; k++) push_ev(t + 3 + N + 2 * L + k, K_CWR, k, 0);
        done_c = t + 2 * N + 2 * L + 3;
      end else begin
        done_c = t + N + L + 3;
      end
      push_ev(done_c, K_DONE, p, 0);
      bs.push_back(t + 1); be.push_back(done_c);
      model_ptr = (p + 1) % N;
    end
    wait_cycles(1);
    ready = 1'b0;
  endtask

  task automatic do_reset();
    int r;
    ev_t nq[$];
    r = cyc;
    rst = 1'b1;
    if (be.size() > 0 && be[be.size()-1] > r) be[be.size()-1] = r;
    foreach (exp_q[i]) if (exp_q[i].cyc <= r) nq.push_back(exp_q[i]);
    exp_q = nq;
    model_ptr = 0;
    ovc.push_back(r + 1); ovv.push_back(0);
    wait_cycles(1);
    rst = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_sample_we"}, int'(sample_we), 0);
    check({tag, "_wr_ptr"}, int'(wr_ptr), 0);
    check({tag, "_rd_addr"}, int'(rd_addr), 0);
    check({tag, "_coef_addr"}, int'(coef_addr), 0);
    check({tag, "_mac_clear"}, int'(mac_clear), 0);
    check({tag, "_mac_en"}, int'(mac_en), 0);
    check({tag, "_err_latch"}, int'(err_latch), 0);
    check({tag, "_coef_we"}, int'(coef_we), 0);
    check({tag, "_coef_wr_addr"}, int'(coef_wr_addr), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  always @(negedge clk) begin
    int   ne, kind;
    ev_t  e;
    if (run_mon) begin
      check("busy", int'(busy), int'(busy_at(cyc)));
      check("overrun", int'(overrun), ov_at(cyc));
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_event kind %0d at cycle %0d: got none expected one", e.kind, e.cyc);
      end
      ne = int'(sample_we) + int'(mac_en) + int'(err_latch) + int'(coef_we) + int'(done);
      if (ne > 1) check("single_event", ne, 1);
      if (!coef_we) check("coef_wr_addr_idle", int'(coef_wr_addr), 0);
      if (ne >= 1) begin
        kind = sample_we ? K_LOAD : mac_en ? K_MAC : err_latch ? K_ERR : coef_we ? K_CWR : K_DONE;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          check("event_kind", kind, e.kind);
          case (e.kind)
            K_LOAD: begin
              check("load_wr_ptr", int'(wr_ptr), e.a);
              check("load_mac_clear", int'(mac_clear), 1);
            end
            K_MAC: begin
              check("filt_rd_addr", int'(rd_addr), e.a);
              check("filt_coef_addr", int'(coef_addr), e.b);
            end
            K_CWR:  check("coef_wr_addr", int'(coef_wr_addr), e.a);
            K_DONE: check("done_wr_ptr", int'(wr_ptr), e.a);
            default: ;
          endcase
        end else begin
          checks++; errors++;
          $display("FAIL unexpected_event cycle %0d: got kind %0d expected none", cyc, kind);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1'b1; ready = 1'b0; adapt = 1'b0;
    ovc.push_back(0); ovv.push_back(0);
    wait_cycles(3);
    rst = 1'b0;
    check_idle_zero("reset");
    run_mon = 1'b1;
    while (cyc < 10) wait_cycles(1);
    strobe(1'b1);
    wait_cycles(100);

    // Minimum legal spacing: next strobe lands one cycle after DONE.
    strobe(1'b1);
    wait_cycles(71);
    strobe(1'b0);
    wait_cycles(40);

    for (int i = 0; i < 34; i++) begin
      strobe(bit'($urandom_range(0, 1)));
      wait_cycles($urandom_range(75, 130));
    end

    t0 = cyc;
    strobe(1'b1);
    wait_cycles(39);
    strobe(1'b0);
    wait_cycles(30);
    strobe(1'b0);
    wait_cycles(60);

    t0 = cyc;
    strobe(1'b1);
    wait_cycles(59);
    do_reset();
    check_idle_zero("midreset");
    wait_cycles(10);
    strobe(1'b1);
    wait_cycles(90);
    strobe(1'b0);
    wait_cycles(60);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
